hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. Each cycle it picks one pipeline action: RUN, STALL, FLUSH or FREEZE. It drives the enables and bubble/flush controls of the PC, IF/ID, ID/EXE and EXE/MEM registers. It also keeps saturating event counters and raises a sticky memory-wait timeout flag.

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: action select, stage enables, event counters, wait timeout
module hazard_ctrl #(
    parameter int ASIZE    = 5,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs1,
    input  logic [ASIZE-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic             ex_wen,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_branch_taken,
    input  logic             ex_jal,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idexe_en,
    output logic             idexe_flush,
    output logic             exemem_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } action_t;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]    WAIT_LIM = WW'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    action_t       action;
    action_t       state_q;
    logic          load_use;
    logic [WW-1:0] wait_cnt;

    // A load in EXE whose destination is read by the instruction in ID; x0 never hazards
    assign load_use = ex_memread && ex_wen && (ex_waddr != '0) &&
                      ((ex_waddr == id_rs1) || (id_uses_rs2 && (ex_waddr == id_rs2)));

    // Pick this cycle's action by priority and decode it to stage controls; reset forces all stages idle/flushed
    always_comb begin
        action      = RUN;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idexe_en    = 1'b1;
        idexe_flush = 1'b0;
        exemem_en   = 1'b1;

        if (mem_busy) begin
            action = FREEZE;
        end else if (ex_branch_taken || ex_jal) begin
            action = FLUSH;
        end else if (load_use) begin
            action = STALL;
        end

        case (action)
            STALL: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idexe_flush = 1'b1;
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
            end
            FREEZE: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idexe_en  = 1'b0;
                exemem_en = 1'b0;
            end
            default: ;
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idexe_en    = 1'b0;
            idexe_flush = 1'b1;
            exemem_en   = 1'b0;
        end
    end

    // Remember the action taken in the cycle just ended
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= action;
        end
    end

    assign state = state_q;

    // Saturating per-action event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (action == STALL && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (action == FLUSH && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (action == FREEZE && freeze_cnt != CNT_MAX) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end
    end

    // Track consecutive memory-wait cycles and latch a sticky timeout when the limit is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (action == FREEZE) begin
            if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == WAIT_LIM - 1'b1) begin
                timeout_err <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int ASIZE    = 5;
    localparam int CNT_W    = 5;
    localparam int MAX_WAIT = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ASIZE-1:0] id_rs1 = '0;
    logic [ASIZE-1:0] id_rs2 = '0;
    logic             id_uses_rs2 = 1'b0;
    logic             ex_memread = 1'b0;
    logic             ex_wen = 1'b0;
    logic [ASIZE-1:0] ex_waddr = '0;
    logic             ex_branch_taken = 1'b0;
    logic             ex_jal = 1'b0;
    logic             mem_busy = 1'b0;
    logic             pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
    logic             timeout_err;

    hazard_ctrl #(.ASIZE(ASIZE), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
        .ex_branch_taken(ex_branch_taken), .ex_jal(ex_jal), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idexe_en(idexe_en), .idexe_flush(idexe_flush), .exemem_en(exemem_en),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .freeze_cnt(freeze_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int m_state, m_stall, m_flush, m_freeze, m_wait;
    bit m_timeout;

    // controls per action: {pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en}
    logic [5:0] ctl_tbl [4];
    initial begin
        ctl_tbl[0] = 6'b110101;
        ctl_tbl[1] = 6'b000111;
        ctl_tbl[2] = 6'b111111;
        ctl_tbl[3] = 6'b000000;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_action();
        bit lu;
        lu = ex_memread && ex_wen && (ex_waddr != 0) &&
             ((ex_waddr == id_rs1) || (id_uses_rs2 && ex_waddr == id_rs2));
        if (mem_busy) return 3;
        if (ex_branch_taken || ex_jal) return 2;
        if (lu) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_freeze = 0; m_wait = 0; m_timeout = 0;
    endtask

    task automatic check_regs();
        check("state", 32'(state), 32'(m_state));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check("freeze_cnt", 32'(freeze_cnt), 32'(m_freeze));
        check("timeout_err", 32'(timeout_err), 32'(m_timeout));
    endtask

    task automatic drive(input int rs1, input int rs2, input bit u2, input bit mr, input bit wen,
                         input int wa, input bit br, input bit jal, input bit busy);
        id_rs1 = ASIZE'(rs1); id_rs2 = ASIZE'(rs2); id_uses_rs2 = u2;
        ex_memread = mr; ex_wen = wen; ex_waddr = ASIZE'(wa);
        ex_branch_taken = br; ex_jal = jal; mem_busy = busy;
    endtask

    task automatic idle();
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // check mid-cycle, then advance the model across the rising edge
    task automatic step();
        int a;
        @(negedge clk);
        a = model_action();
        check("ctl", 32'({pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en}), 32'(ctl_tbl[a]));
        check_regs();
        @(posedge clk);
        m_state = a;
        if (a == 1) m_stall  = (m_stall  < CMAX) ? m_stall  + 1 : CMAX;
        if (a == 2) m_flush  = (m_flush  < CMAX) ? m_flush  + 1 : CMAX;
        if (a == 3) m_freeze = (m_freeze < CMAX) ? m_freeze + 1 : CMAX;
        if (a == 3) begin
            if (m_wait < MAX_WAIT) m_wait++;
            if (m_wait == MAX_WAIT) m_timeout = 1;
        end else begin
            m_wait = 0;
        end
        #1;
    endtask

    // asynchronous reset pulse placed between edges
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check("rst_ctl", 32'({pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en}), 32'(6'b001010));
        check_regs();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // load-use on rs1, then hazard gone
        drive(3, 9, 0, 1, 1, 3, 0, 0, 0); step();
        idle(); step();
        step();

        // guards: x0 destination, rs2 unused, rs2 used
        drive(0, 0, 1, 1, 1, 0, 0, 0, 0); step();
        drive(1, 7, 0, 1, 1, 7, 0, 0, 0); step();
        drive(1, 7, 1, 1, 1, 7, 0, 0, 0); step();
        idle(); step();

        // branch wins over load-use; jal alone
        drive(3, 0, 0, 1, 1, 3, 1, 0, 0); step();
        drive(1, 2, 0, 0, 0, 0, 0, 1, 0); step();
        idle(); step();

        // freeze holding a taken branch, then a single flush
        do_reset();
        repeat (5) begin drive(1, 2, 0, 0, 0, 0, 1, 0, 1); step(); end
        drive(1, 2, 0, 0, 0, 0, 1, 0, 0); step();
        idle(); step();
        check("flush_once", 32'(flush_cnt), 32'd1);
        check("freeze5", 32'(freeze_cnt), 32'd5);

        // timeout after exactly MAX_WAIT busy cycles, sticky
        do_reset();
        repeat (3) begin drive(1, 2, 0, 0, 0, 0, 0, 0, 1); step(); end
        check("to_after3", 32'(timeout_err), 32'd0);
        step();
        check("to_after4", 32'(timeout_err), 32'd1);
        idle(); step(); step();

        // 3 busy / 1 idle / 3 busy never times out
        do_reset();
        repeat (3) begin drive(1, 2, 0, 0, 0, 0, 0, 0, 1); step(); end
        idle(); step();
        repeat (3) begin drive(1, 2, 0, 0, 0, 0, 0, 0, 1); step(); end
        idle(); step();
        check("to_gap", 32'(timeout_err), 32'd0);

        // reset during freeze with counters nonzero, then a fresh RUN
        drive(4, 0, 0, 1, 1, 4, 0, 0, 0); step();
        repeat (2) begin drive(1, 2, 0, 0, 0, 0, 0, 0, 1); step(); end
        do_reset();
        idle(); step();
        step();

        // randomized traffic with small register space to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                  (i % 40 < 6) ? 1'b1 : ($urandom_range(0, 3) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
